// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply, restoring divide, sign fix-up, then writeback.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_is_div;
    logic                 r_dz;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_legal;
    logic                 w_signed;
    logic                 w_div;
    logic                 w_bz;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_rsh;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [WIDTH-1:0]     w_q_s;
    logic [WIDTH-1:0]     w_r_s;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [2*WIDTH-1:0]   w_fix;

    // Decode the request and form operand magnitudes.
    always_comb begin
        w_legal  = (alu_control[3:1] == 3'b101) ||
                   (alu_control[3:1] == 3'b110);
        w_signed = ~alu_control[0];
        w_div    = alu_control[2];
        w_bz     = (B == '0);
        w_abs_a  = (w_signed && A[WIDTH-1]) ? -A : A;
        w_abs_b  = (w_signed && B[WIDTH-1]) ? -B : B;
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
        w_rsh  = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_rsh - {1'b0, r_b};
    end

    // Sign correction; divide-by-zero forces an all-ones quotient and
    // the dividend as remainder, which the remainder sign restores to A.
    always_comb begin
        w_q      = r_dz ? '1 : r_acc[WIDTH-1:0];
        w_r      = r_dz ? r_a : r_acc[2*WIDTH-1:WIDTH];
        w_q_s    = (r_neg_q && !r_dz) ? -w_q : w_q;
        w_r_s    = r_neg_r ? -w_r : w_r;
        w_prod_s = r_neg_q ? -r_acc : r_acc;
        w_fix    = r_is_div ? {w_r_s, w_q_s} : w_prod_s;
    end

    // Control FSM, datapath registers and HI/LO ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start && w_legal) begin
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_acc    <= {{WIDTH{1'b0}},
                                     w_div ? w_abs_a : w_abs_b};
                        r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r  <= w_signed & w_div & A[WIDTH-1];
                        r_is_div <= w_div;
                        r_dz     <= w_div & w_bz;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (!w_div)
                            r_state <= S_MUL;
                        else if (w_bz)
                            r_state <= S_FIX;
                        else
                            r_state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (r_acc[0])
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    else
                        r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (!w_diff[WIDTH])
                        r_acc <= {w_diff[WIDTH-1:0],
                                  r_acc[WIDTH-2:0], 1'b1};
                    else
                        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    // First cycle applies signs, second commits HI/LO.
                    if (r_cnt == '0) begin
                        r_acc <= w_fix;
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_hi    <= r_acc[2*WIDTH-1:WIDTH];
                        r_lo    <= r_acc[WIDTH-1:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, MTHI/MTLO, reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_unit;

    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_control = 4'b0000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_control(alu_control), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one rising edge (edge E).
    task automatic launch(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; alu_control = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; alu_control = 4'b0000;
    endtask

    // Count edges after E until done; also count busy-high samples.
    task automatic finish_op(input string tag, input int exp_lat,
                             input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int k = 0;
        int nb = 0;
        while (!done && k < 100) begin
            if (busy) nb++;
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
        chk({tag, "_busy_off"}, 64'(busy), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int k;
        int ndone;

        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        finish_op("mult", 34, 32'hFFFFFFFF, 32'hFFFFFFEB);

        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu", 34, 32'hFFFFFFFE, 32'h00000001);

        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        finish_op("div_neg", 34, 32'hFFFFFFFF, 32'hFFFFFFFD);

        launch(OP_DIVU, 32'd100, 32'd7);
        finish_op("divu", 34, 32'd2, 32'd14);

        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_ovf", 34, 32'h0, 32'h80000000);

        launch(OP_DIVU, 32'h1234, 32'h0);
        finish_op("divu_z", 2, 32'h1234, 32'hFFFFFFFF);

        launch(OP_DIV, 32'hFFFFFFFB, 32'h0);
        finish_op("div_z", 2, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Unsupported code with start: nothing happens.
        launch(4'b0010, 32'd3, 32'd4);
        chk("illegal_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("illegal_done", 64'(done), 64'(0));

        // MTHI in IDLE.
        hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'h11);

        // Start and write ignored while busy.
        launch(OP_MULT, 32'd5, 32'd6);
        k = 0;
        while (k < 9) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1; alu_control = OP_DIVU; A = 32'd9; B = 32'd3;
        hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0; alu_control = 4'b0000; hi_we = 1'b0;
        chk("busy_wr_drop", 64'(hi), 64'h11);
        k = 10;
        ndone = 0;
        while (k < 60) begin
            if (done) begin
                ndone++;
                chk("ign_lat", 64'(k), 64'(34));
            end
            @(negedge clk);
            k++;
        end
        chk("ign_ndone", 64'(ndone), 64'(1));
        chk("ign_hi", 64'(hi), 64'(0));
        chk("ign_lo", 64'(lo), 64'(30));

        // Reset mid-operation.
        launch(OP_MULT, 32'd5, 32'd6);
        k = 0;
        while (k < 14) begin
            @(negedge clk);
            k++;
        end
        chk("mid_busy", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (done) ndone++;
            k++;
        end
        chk("arst_nodone", 64'(ndone), 64'(0));
        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h55);
        chk("mtlo_hi", 64'(hi), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide responder for the MIPS datapath.
- Services the ALU control codes the combinational ALU does not execute: MULT 4'b1010, MULTU 4'b1011, DIV 4'b1100, DIVU 4'b1101.
- Owns the architectural HI/LO registers.
- Also accepts MTHI/MTLO writes; the stall logic reads busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- alu_control  in  4  operation code; only 1010/1011/1100/1101 launch an operation.
- A  in  WIDTH  multiplicand / dividend.
- B  in  WIDTH  multiplier / divisor.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Applies immediately, including mid-operation; an in-flight result is discarded.
- States: IDLE, MUL, DIV, FIX.
- Accept: in IDLE, start=1 and alu_control is one of the four codes, at edge E.
  - Latch |A| and |B| (signed ops) or A and B (unsigned ops).
  - Latch the sign flags and the op.
  - Set counter=0 and busy=1.
  - Go to MUL or DIV.
- Other alu_control values with start=1 are ignored and the block stays in IDLE.
- MUL: unsigned shift-add, one multiplier bit per cycle into a 2*WIDTH product. Exactly WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
  - B=0 at accept skips DIV and goes straight to FIX.
- FIX, one cycle, then write HI/LO:
  - MULT: negate the 64-bit product if sign(A)≠sign(B). HI=product[63:32], LO=product[31:0].
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF wraps naturally: LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=original A.
- Timing:
  - Normal operation: HI/LO written at edge E+WIDTH+2 (E+34). done=1 and busy=0 in the cycle following that edge, then return to IDLE.
  - Divide by zero: written at E+2.
  - busy is high from E until the completing edge.
- done: exactly one cycle per completed operation; 0 otherwise.
- start while busy: ignored. No queueing, no abort.
- A and B changes while busy have no effect.
- MTHI/MTLO:
  - hi_we or lo_we in IDLE writes wdata to the selected register at that edge. Both asserted writes both.
  - Writes while busy are dropped.
  - Write in the same cycle as an accepted start: the write takes effect; the later result overwrites it.
- No other HI/LO modification. HI/LO hold their values indefinitely.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7 → at E+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, done one cycle, busy high for 34 cycles.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 → LO=14, HI=2.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU A=0x1234, B=0 → at E+2: LO=0xFFFFFFFF, HI=0x1234.
- Start MULT 5×6, then pulse start with DIVU 9/3 and hi_we wdata=0xAA at E+10 → both ignored. Result HI=0, LO=30; single done pulse.
- Start MULT, drive rst_n=0 at E+15 → hi=lo=0, busy=0 immediately. No done after release. A subsequent lo_we wdata=0x55 in IDLE → lo=0x55 next edge.
